// File: rtl/usr_pkg.sv
// usr_pkg: shared modes, burst FSM states and next-state function for univ_shift_reg.
package usr_pkg;
    localparam int MAXW = 64;
    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROTL = 3'd4;
    localparam logic [2:0] MODE_ROTR = 3'd5;
    typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, DONE = 2'd2} state_t;
    typedef struct packed {
        logic [MAXW-1:0] q;
        logic            sout;
        logic            upd;
    } nxt_t;
    // Operates on a zero-extended register of w live bits so any WIDTH <= MAXW shares it.
    function automatic nxt_t next_qs(input logic [MAXW-1:0] q, input logic [MAXW-1:0] d,
                                     input logic sin, input logic [2:0] mode, input int w);
        logic [MAXW-1:0] mask, shl, shr;
        logic top, lsb, msb, left, right;
        nxt_t r;
        mask  = (MAXW'(1) << w) - MAXW'(1);
        top   = 1'(q >> (w - 1));
        lsb   = mode == MODE_SHL ? sin : top;
        msb   = mode == MODE_SHR ? sin : q[0];
        shl   = {q[MAXW-2:0], lsb} & mask;
        shr   = (q >> 1) | (MAXW'(msb) << (w - 1));
        left  = mode == MODE_SHL || mode == MODE_ROTL;
        right = mode == MODE_SHR || mode == MODE_ROTR;
        r.q    = mode == MODE_LOAD ? d : left ? shl : right ? shr : q;
        r.sout = left ? top : q[0];
        r.upd  = left || right;
        return r;
    endfunction
endpackage

// File: rtl/usr_burst_ctrl.sv
// usr_burst_ctrl: burst FSM and shift down-counter; issues apply strobes to the datapath.
module usr_burst_ctrl import usr_pkg::*; #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             apply,
    output logic [2:0]       amode
);
    state_t           state;
    logic [CNT_W-1:0] ctr;
    logic [2:0]       lmode;
    logic             go;
    assign go    = state == IDLE && start && (mode inside {MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR});
    assign apply = state == BURST || (state == IDLE && !go && en);
    assign amode = state == BURST ? lmode : mode;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ctr   <= '0;
            lmode <= MODE_HOLD;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go) begin
                lmode <= mode;
                ctr   <= cnt;
                state <= cnt == '0 ? DONE : BURST;
                busy  <= cnt != '0;
                done  <= cnt == '0;
            end else if (state == BURST) begin
                ctr <= ctr - CNT_W'(1);
                if (ctr == CNT_W'(1)) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register with autonomous shift bursts.
module univ_shift_reg import usr_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] in,
    input  logic             sin,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);
    logic       apply;
    logic [2:0] amode;
    nxt_t       nx;
    logic       unused_nx;
    usr_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start), .cnt(cnt),
        .busy(busy), .done(done), .apply(apply), .amode(amode)
    );
    assign nx        = next_qs(MAXW'(q), MAXW'(in), sin, amode, WIDTH);
    assign unused_nx = ^nx;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= '0;
            sout <= 1'b0;
        end else if (apply) begin
            q <= nx.q[WIDTH-1:0];
            if (nx.upd) sout <= nx.sout;
        end
    end
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised successor to the team's 4-bit parallel-in/parallel-out register, generalised to WIDTH bits.
- Supports hold, parallel load, logical shift left/right and rotate left/right, with serial in and serial out.
- Adds a burst engine: a single start request performs a programmable number of shifts autonomously, with busy/done status.
- Used as the datapath staging register ahead of the serialisers.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, width of burst shift-count input; max burst = 2^CNT_W-1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
en  input  1  qualifies mode for single-cycle operation when idle
mode  input  3  operation select (encoding below)
in  input  WIDTH  parallel load data
sin  input  1  serial input for SHL/SHR
start  input  1  burst request (sampled when idle)
cnt  input  CNT_W  number of shifts in burst
q  output  WIDTH  register contents
sout  output  1  last bit shifted/rotated out
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset (rst=0, async): q=0, sout=0, busy=0, done=0, FSM=IDLE, internal counter=0, latched mode=HOLD.
- Mode encoding:
  - 0 HOLD
  - 1 LOAD: q<=in
  - 2 SHL: q<={q[W-2:0],sin}, sout<=q[W-1]
  - 3 SHR: q<={sin,q[W-1:1]}, sout<=q[0]
  - 4 ROTL: q<={q[W-2:0],q[W-1]}, sout<=q[W-1]
  - 5 ROTR: q<={q[0],q[W-1:1]}, sout<=q[0]
  - 6, 7: reserved, treated as HOLD
- sout changes only on shift/rotate cycles; it holds during HOLD and LOAD.
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - If start=1 and mode in 2..5: latch mode and cnt. If cnt=0, go to DONE; else go to BURST. No q change that cycle.
  - start has priority over en.
  - start=1 with mode 0,1,6,7: start is ignored, and the en/mode single-cycle rule applies that cycle.
  - Else if en=1: apply mode for one cycle (1-cycle latency: q visible the cycle after the edge).
  - en=0: hold.
- BURST:
  - busy=1.
  - Each cycle: apply latched mode once, decrement counter. sin is sampled live each cycle.
  - When the shift with counter==1 executes, go to DONE.
  - en, mode, start, cnt are ignored.
- DONE:
  - done=1 for exactly one cycle, busy=0; return to IDLE.
  - start/en presented in DONE are ignored.
- Burst of N shifts: busy high exactly N cycles; done on cycle N+1 after the start edge; q final when done is high.
- Maximum count 2^CNT_W-1; no wrap. Counter never underflows.
- Rotations with N=WIDTH restore the original q.
- Reset asserted mid-burst: immediate clear to reset values; no done pulse.
- All outputs registered; no combinational input-to-output paths.

Decomposition:
- Package usr_pkg: mode localparams (MODE_HOLD..MODE_ROTR), FSM state encoding (IDLE/BURST/DONE, 2 bits), and a function computing next q/sout from (q, sin, mode).
- Sub-module usr_burst_ctrl holds the FSM and down-counter; it outputs the busy/done and apply strobes. The top holds the q/sout datapath.

Test Plan:
- WIDTH=4. Reset low 10ns then high; en=1, mode=LOAD, in=4'b1001 -> q=4'b1001 one cycle later. Then mode=HOLD for 5 cycles -> q stays 1001, sout=0.
- q=1001, single-cycle SHL with sin=1 -> q=0011, sout=1. Then SHR with sin=0 -> q=0001, sout=1.
- q=1001, start=1, mode=ROTR, cnt=3 -> busy high 3 cycles; q sequence 1100, 0110, 0011; done pulse the next cycle, q=0011. Stimulus toggles on en/mode during the burst have no effect.
- start with cnt=0, mode=SHL -> no q change, busy never high, done pulse one cycle after start.
- Burst ROTL cnt=4 on q=1010 with reset asserted after 2 shifts -> q=0, busy=0, done never pulses, sout=0.
- start=1 with mode=LOAD, en=1, in=0110 -> burst ignored, q=0110 next cycle, busy/done stay 0.
